// File: rtl/serial_subtractor_if.sv
// Start/operand request and result bus of the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor step per clock, LSB first,
// result and final borrow valid with a one-cycle done pulse after WIDTH steps.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, start acceptance and the full-subtractor step
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_d          = r_a[0] ^ r_b[0] ^ r_br;
        w_br_next    = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_last = (r_cnt == CNT_W'(WIDTH - 1));
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A start here chains straight into the next operation
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_SHIFT);
            r_done <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_a    <= bus.a;
                r_b    <= bus.b;
                r_diff <= '0;
                r_br   <= 1'b0;
                r_cnt  <= '0;
            end else if (r_state == S_SHIFT) begin
                r_a    <= r_a >> 1;
                r_b    <= r_b >> 1;
                r_diff <= {w_d, r_diff[WIDTH-1:1]};
                r_br   <= w_br_next;
                // Counter parks at WIDTH-1 on the last step instead of wrapping
                if (!w_last) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.diff   = r_diff;
    assign bus.borrow = r_br;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner sequences,
// random 8-bit operands and an exhaustive 4-bit sweep against a - b arithmetic.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: plain integer subtraction reduced modulo 2^w
    task automatic ref_sub(input int w, input int a, input int b,
                           output logic [7:0] d, output logic br);
        int m;
        int r;
        m  = 1 << w;
        r  = a - b;
        br = (r < 0);
        d  = 8'((r + m) % m);
    endtask

    // Called positioned at a negedge; returns positioned at the done negedge (or timeout)
    task automatic run_op(input bit sel4, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output logic br, output int lat,
                          output bit busy_ok);
        if (sel4) begin
            if4.start = 1'b1; if4.a = a[3:0]; if4.b = b[3:0];
        end else begin
            if8.start = 1'b1; if8.a = a; if8.b = b;
        end
        @(posedge clk);
        @(negedge clk);
        if4.start = 1'b0;
        if8.start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!(sel4 ? if4.done : if8.done) && lat < 40) begin
            if (!(sel4 ? if4.busy : if8.busy)) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        d  = sel4 ? {4'b0, if4.diff} : if8.diff;
        br = sel4 ? if4.borrow : if8.borrow;
    endtask

    vec_t       tbl[8];
    logic [7:0] d;
    logic [7:0] ed;
    logic       br;
    logic       ebr;
    int         lat;
    bit         ok;
    logic [7:0] ra;
    logic [7:0] rb;

    initial begin
        n_pass  = 0;
        n_total = 0;
        tbl[0] = '{"5-3",     8'd5,   8'd3,   8'h02, 1'b0};
        tbl[1] = '{"3-5",     8'd3,   8'd5,   8'hFE, 1'b1};
        tbl[2] = '{"0-1",     8'h00,  8'h01,  8'hFF, 1'b1};
        tbl[3] = '{"FF-FF",   8'hFF,  8'hFF,  8'h00, 1'b0};
        tbl[4] = '{"0-0",     8'h00,  8'h00,  8'h00, 1'b0};
        tbl[5] = '{"80-01",   8'h80,  8'h01,  8'h7F, 1'b0};
        tbl[6] = '{"10-20",   8'h10,  8'h20,  8'hF0, 1'b1};
        tbl[7] = '{"AA-55",   8'hAA,  8'h55,  8'h55, 1'b0};

        rst_n = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0;
        #12;
        check("rst busy", 32'(if8.busy), 32'd0);
        check("rst done", 32'(if8.done), 32'd0);
        check("rst diff", 32'(if8.diff), 32'd0);
        check("rst borrow", 32'(if8.borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, tbl[i].a, tbl[i].b, d, br, lat, ok);
            check({tbl[i].name, " diff"}, 32'(d), 32'(tbl[i].d));
            check({tbl[i].name, " borrow"}, 32'(br), 32'(tbl[i].br));
            check({tbl[i].name, " latency"}, 32'(lat), 32'd8);
            check({tbl[i].name, " busy"}, 32'(ok), 32'd1);
            if (i == 0) begin
                @(negedge clk);
                check("done one cycle", 32'(if8.done), 32'd0);
                check("idle busy", 32'(if8.busy), 32'd0);
                check("diff hold", 32'(if8.diff), 32'h02);
                check("borrow hold", 32'(if8.borrow), 32'd0);
            end
        end

        // Start held high with operands changing during SHIFT
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h37; if8.b = 8'h12;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        ok  = 1'b1;
        while (!if8.done && lat < 40) begin
            if (!if8.busy) ok = 1'b0;
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        if8.start = 1'b0;
        check("held diff", 32'(if8.diff), 32'h25);
        check("held borrow", 32'(if8.borrow), 32'd0);
        check("held latency", 32'(lat), 32'd8);
        check("held busy", 32'(ok), 32'd1);
        @(negedge clk);

        // Back-to-back: second start issued in the DONE cycle
        run_op(1'b0, 8'hC8, 8'h64, d, br, lat, ok);
        check("b2b first diff", 32'(d), 32'h64);
        check("b2b first borrow", 32'(br), 32'd0);
        run_op(1'b0, 8'h01, 8'h02, d, br, lat, ok);
        check("b2b second diff", 32'(d), 32'hFF);
        check("b2b second borrow", 32'(br), 32'd1);
        check("b2b second latency", 32'(lat), 32'd8);
        check("b2b second busy", 32'(ok), 32'd1);
        @(negedge clk);

        // Reset during SHIFT cycle 4
        if8.start = 1'b1; if8.a = 8'hF0; if8.b = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(if8.busy), 32'd0);
        check("abort done", 32'(if8.done), 32'd0);
        check("abort diff", 32'(if8.diff), 32'd0);
        check("abort borrow", 32'(if8.borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (if8.done) ok = 1'b0;
        end
        check("abort no done", 32'(ok), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'h80, 8'h01, d, br, lat, ok);
        check("post-rst diff", 32'(d), 32'h7F);
        check("post-rst borrow", 32'(br), 32'd0);
        check("post-rst latency", 32'(lat), 32'd8);
        @(negedge clk);

        // Random 8-bit operands
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ref_sub(8, int'(ra), int'(rb), ed, ebr);
            run_op(1'b0, ra, rb, d, br, lat, ok);
            check($sformatf("rnd %0h-%0h diff", ra, rb), 32'(d), 32'(ed));
            check($sformatf("rnd %0h-%0h borrow", ra, rb), 32'(br), 32'(ebr));
            check($sformatf("rnd %0h-%0h latency", ra, rb), 32'(lat), 32'd8);
        end
        @(negedge clk);

        // Every 4-bit operand pair
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                ref_sub(4, x, y, ed, ebr);
                run_op(1'b1, 8'(x), 8'(y), d, br, lat, ok);
                check($sformatf("w4 %0d-%0d diff", x, y), 32'(d), 32'(ed));
                check($sformatf("w4 %0d-%0d borrow", x, y), 32'(br), 32'(ebr));
                check($sformatf("w4 %0d-%0d latency", x, y), 32'(lat), 32'd4);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on the rising edge of clk.
REQ-005 SHALL have port a, input, WIDTH bits: minuend, unsigned, sampled when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, unsigned, sampled when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse that marks the result as valid.
REQ-009 SHALL have port diff, output, WIDTH bits: result, a - b modulo 2^WIDTH.
REQ-010 SHALL have port borrow, output, 1 bit: final borrow out, high when a < b.

Function
REQ-011 SHALL implement a three-state FSM:
  - IDLE to SHIFT on accepted start.
  - SHIFT to DONE after exactly WIDTH SHIFT cycles.
  - DONE to IDLE unconditionally, unless start is accepted in DONE (see REQ-017).
REQ-012 SHALL accept start only when busy = 0, i.e. in IDLE or DONE.
REQ-013 SHALL, on accepting start, perform all of the following:
  - load a and b into internal shift registers;
  - clear the internal borrow flip-flop to 0;
  - clear the bit counter to 0;
  - clear the diff shift register;
  - enter SHIFT.
REQ-014 SHALL process one bit per SHIFT cycle, LSB first, using full-subtractor logic:
  - d = a_i XOR b_i XOR br;
  - br_next = (NOT a_i AND b_i) OR (NOT (a_i XOR b_i) AND br);
  - d is shifted into the diff register from the MSB side.
REQ-015 SHALL hold busy = 1 in every SHIFT cycle and busy = 0 in IDLE and DONE.
REQ-016 SHALL meet the following timing for done:
  - done = 1 for exactly one cycle, in DONE only;
  - with start accepted at edge N, done is high in the cycle after edge N+WIDTH (latency WIDTH+1 clocks).
REQ-017 SHALL treat a start accepted in DONE as back-to-back:
  - done still pulses in that cycle;
  - the new operation begins on the same edge, exactly as from IDLE.
REQ-018 SHALL hold diff and borrow stable and valid from the DONE cycle until the next accepted start.
REQ-019 SHALL ignore start, a and b while busy = 1, with no effect on the running operation.
REQ-020 SHALL reset the bit counter to 0 on each accepted start, and SHALL NOT let it wrap or exceed WIDTH-1 in SHIFT.
REQ-021 SHALL use no combinational path from any input to any output; all outputs are registered.

Reset
REQ-022 SHALL, when rst_n = 0, immediately force all of the following, regardless of clk:
  - state = IDLE;
  - busy = 0, done = 0, diff = 0, borrow = 0;
  - counter and internal borrow = 0.
REQ-023 SHALL abort any operation in progress when rst_n is asserted mid-SHIFT:
  - no done pulse is produced for the aborted operation;
  - after rst_n deasserts, a new start is accepted normally.
REQ-024 SHALL release from reset synchronously: the first accepted start is on the first rising edge with rst_n = 1.

Verification
REQ-025 SHALL pass: WIDTH=8, a=8'd5, b=8'd3, start pulse -> done after 9 clocks, diff=8'h02, borrow=0.
REQ-026 SHALL pass: WIDTH=8, a=8'd3, b=8'd5 -> diff=8'hFE, borrow=1; and a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1.
REQ-027 SHALL pass: a=b=8'hFF -> diff=8'h00, borrow=0; and a=b=8'h00 -> diff=8'h00, borrow=0.
REQ-028 SHALL pass: start held high with a and b changing during SHIFT -> result equals the operands captured at the first edge, and busy never drops early.
REQ-029 SHALL pass: back-to-back ops, start asserted in the DONE cycle with new operands -> first result is seen with done, second done follows 9 clocks later with the correct second result.
REQ-030 SHALL pass: rst_n pulsed low at SHIFT cycle 4 -> all outputs 0 immediately, no done; a new op of 8'h80 - 8'h01 -> diff=8'h7F, borrow=0.
REQ-031 SHALL pass: random exhaustive compare against the reference a - b for WIDTH=4 (all 256 pairs).
